// File: rtl/udp_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udp_stream_pkg: shared constants for the multi-channel UDP sender  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package udp_stream_pkg;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_REQ  = 3'd1;
  localparam logic [2:0] c_ST_HDR  = 3'd2;
  localparam logic [2:0] c_ST_INFO = 3'd3;
  localparam logic [2:0] c_ST_DATA = 3'd4;
  localparam logic [2:0] c_ST_GAP  = 3'd5;

  localparam logic [1:0] c_HDR_DST_IP = 2'd0;
  localparam logic [1:0] c_HDR_SRC_IP = 2'd1;
  localparam logic [1:0] c_HDR_PORTS  = 2'd2;
  localparam logic [1:0] c_HDR_LEN    = 2'd3;

  localparam int c_INFO_LAST    = 31;
  localparam int c_INFO_CH_HI   = 30;
  localparam int c_INFO_CH_LO   = 24;
  localparam int c_INFO_ADDR_HI = 23;
  localparam int c_INFO_ADDR_LO = 0;

  // Payload byte length: n data words plus the INFO word.
  function automatic logic [15:0] udp_len(input logic [15:0] n);
    return (n + 16'd1) << 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_stream_tx_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter: picks the first eligible channel after the pointer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              advance,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  int w_idx;

  // Scan from farthest to nearest so the channel closest after ptr wins.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    w_idx = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = (int'(ptr) + k) % NUM_CH;
      if (eligible[w_idx]) begin
        grant = IDX_W'(w_idx);
        valid = advance;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/udp_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udp_stream_tx: round-robin FWFT FIFO drain into UDP core packets   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module udp_stream_tx
  import udp_stream_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [31:0]                        cfg_dst_ip,
  input  logic [31:0]                        cfg_src_ip,
  input  logic [15:0]                        cfg_dst_port,
  input  logic [15:0]                        cfg_src_port,
  input  logic [$clog2(MAX_WORDS+1)-1:0]     cfg_words,
  input  logic [23:0]                        cfg_interval,
  input  logic [NUM_CH*CNT_W-1:0]            ch_count,
  input  logic [NUM_CH*32-1:0]               ch_data,
  input  logic [NUM_CH*24-1:0]               ch_addr,
  input  logic [NUM_CH-1:0]                  ch_final,
  output logic [NUM_CH-1:0]                  ch_rd,
  output logic                               w_req,
  input  logic                               w_ack,
  output logic                               w_enable,
  output logic [31:0]                        w_data,
  output logic                               frame_done,
  output logic [6:0]                         frame_ch
);

  localparam int c_WW = $clog2(MAX_WORDS + 1);
  localparam int c_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  generate
    if (NUM_CH < 1 || NUM_CH > 128 || MAX_WORDS < 1 || MAX_WORDS > 16382) begin : g_param_check
      $error("udp_stream_tx: unsupported NUM_CH or MAX_WORDS");
    end
  endgenerate

  logic [2:0]        r_state;
  logic [c_IW-1:0]   r_ptr;
  logic [c_IW-1:0]   r_ch;
  logic [c_WW-1:0]   r_n;
  logic              r_last;
  logic [31:0]       r_dst_ip;
  logic [31:0]       r_src_ip;
  logic [15:0]       r_dst_port;
  logic [15:0]       r_src_port;
  logic [23:0]       r_interval;
  logic [23:0]       r_cnt;
  logic              r_wen;
  logic [31:0]       r_wdata;
  logic              r_frame_done;
  logic [6:0]        r_frame_ch;
  logic [NUM_CH-1:0] r_done;

  logic [c_WW-1:0]   w_len;
  logic [CNT_W-1:0]  w_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_fin_pend;
  logic              w_fin_any;
  logic [c_IW-1:0]   w_fin_idx;
  logic [c_IW-1:0]   w_gnt;
  logic              w_gnt_valid;
  logic [c_WW-1:0]   w_n;
  logic              w_last;
  logic [31:0]       w_hdr;
  logic [NUM_CH-1:0] w_rd;

  always_comb begin
    if (cfg_words == '0)
      w_len = c_WW'(1);
    else if (32'(cfg_words) > 32'(MAX_WORDS))
      w_len = c_WW'(MAX_WORDS);
    else
      w_len = cfg_words;
  end

  // A finished channel with an empty FIFO owes a frame_done before any packet.
  always_comb begin
    w_fin_any = 1'b0;
    w_fin_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt[c]      = ch_count[c*CNT_W +: CNT_W];
      w_elig[c]     = (32'(w_cnt[c]) >= 32'(w_len)) || (ch_final[c] && (w_cnt[c] != '0));
      w_fin_pend[c] = ch_final[c] && (w_cnt[c] == '0) && !r_done[c];
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_fin_pend[c]) begin
        w_fin_any = 1'b1;
        w_fin_idx = c_IW'(c);
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (c_IW)
  ) u_arb (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .advance  ((r_state == c_ST_IDLE) && !w_fin_any),
    .grant    (w_gnt),
    .valid    (w_gnt_valid)
  );

  always_comb begin
    if (32'(w_cnt[w_gnt]) >= 32'(w_len)) begin
      w_n    = w_len;
      w_last = ch_final[w_gnt] && (32'(w_cnt[w_gnt]) == 32'(w_len));
    end else begin
      w_n    = c_WW'(w_cnt[w_gnt]);
      w_last = ch_final[w_gnt];
    end
  end

  always_comb begin
    case (r_cnt[1:0])
      c_HDR_DST_IP: w_hdr = r_dst_ip;
      c_HDR_SRC_IP: w_hdr = r_src_ip;
      c_HDR_PORTS:  w_hdr = {r_src_port + 16'(r_ch), r_dst_port};
      c_HDR_LEN:    w_hdr = {16'd0, udp_len(16'(r_n))};
      default:      w_hdr = '0;
    endcase
  end

  always_comb begin
    w_rd = '0;
    if (r_state == c_ST_DATA)
      w_rd[r_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_ptr        <= c_IW'(NUM_CH - 1);
      r_ch         <= '0;
      r_n          <= '0;
      r_last       <= 1'b0;
      r_dst_ip     <= '0;
      r_src_ip     <= '0;
      r_dst_port   <= '0;
      r_src_port   <= '0;
      r_interval   <= '0;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_frame_ch   <= '0;
      r_done       <= '0;
    end else begin
      r_wen        <= 1'b0;
      r_frame_done <= 1'b0;
      r_done       <= r_done & ch_final;
      case (r_state)
        c_ST_IDLE: begin
          if (w_fin_any) begin
            r_frame_done       <= 1'b1;
            r_frame_ch         <= 7'(w_fin_idx);
            r_done[w_fin_idx]  <= 1'b1;
          end else if (w_gnt_valid) begin
            r_ch       <= w_gnt;
            r_ptr      <= w_gnt;
            r_n        <= w_n;
            r_last     <= w_last;
            r_dst_ip   <= cfg_dst_ip;
            r_src_ip   <= cfg_src_ip;
            r_dst_port <= cfg_dst_port;
            r_src_port <= cfg_src_port;
            r_interval <= cfg_interval;
            r_state    <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          r_cnt <= '0;
          if (w_ack)
            r_state <= c_ST_HDR;
        end
        c_ST_HDR: begin
          r_wen   <= 1'b1;
          r_wdata <= w_hdr;
          if (r_cnt[1:0] == c_HDR_LEN) begin
            r_cnt   <= '0;
            r_state <= c_ST_INFO;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_INFO: begin
          r_wen <= 1'b1;
          r_wdata[c_INFO_LAST]                    <= r_last;
          r_wdata[c_INFO_CH_HI:c_INFO_CH_LO]      <= 7'(r_ch);
          r_wdata[c_INFO_ADDR_HI:c_INFO_ADDR_LO]  <= ch_addr[24*r_ch +: 24];
          r_state <= c_ST_DATA;
        end
        c_ST_DATA: begin
          r_wen   <= 1'b1;
          r_wdata <= ch_data[32*r_ch +: 32];
          if (r_cnt == 24'(r_n) - 24'd1) begin
            r_cnt   <= '0;
            r_state <= c_ST_GAP;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_GAP: begin
          if (r_cnt >= r_interval)
            r_state <= c_ST_IDLE;
          else
            r_cnt <= r_cnt + 24'd1;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign ch_rd      = w_rd;
  assign w_req      = (r_state == c_ST_REQ);
  assign w_enable   = r_wen;
  assign w_data     = r_wdata;
  assign frame_done = r_frame_done;
  assign frame_ch   = r_frame_ch;

endmodule
`default_nettype wire

// File: tb/tb_udp_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_udp_stream_tx: directed bench for udp_stream_tx (4 channels)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_udp_stream_tx;

  localparam int c_NCH = 4;
  localparam int c_CW  = 11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [31:0]            cfg_dst_ip;
  logic [31:0]            cfg_src_ip;
  logic [15:0]            cfg_dst_port;
  logic [15:0]            cfg_src_port;
  logic [8:0]             cfg_words;
  logic [23:0]            cfg_interval;
  logic [c_NCH*c_CW-1:0]  ch_count;
  logic [c_NCH*32-1:0]    ch_data;
  logic [c_NCH*24-1:0]    ch_addr;
  logic [c_NCH-1:0]       ch_final;
  logic [c_NCH-1:0]       ch_rd;
  logic                   w_req;
  logic                   w_ack;
  logic                   w_enable;
  logic [31:0]            w_data;
  logic                   frame_done;
  logic [6:0]             frame_ch;

  int checks   = 0;
  int failures = 0;

  udp_stream_tx #(
    .NUM_CH    (c_NCH),
    .MAX_WORDS (256),
    .CNT_W     (c_CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_dst_ip   (cfg_dst_ip),
    .cfg_src_ip   (cfg_src_ip),
    .cfg_dst_port (cfg_dst_port),
    .cfg_src_port (cfg_src_port),
    .cfg_words    (cfg_words),
    .cfg_interval (cfg_interval),
    .ch_count     (ch_count),
    .ch_data      (ch_data),
    .ch_addr      (ch_addr),
    .ch_final     (ch_final),
    .ch_rd        (ch_rd),
    .w_req        (w_req),
    .w_ack        (w_ack),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .frame_done   (frame_done),
    .frame_ch     (frame_ch)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: word k of channel c is {c, k}, its address {c, k}.
  int tot  [c_NCH] = '{default: 0};
  int head [c_NCH] = '{default: 0};

  always @(posedge clk)
    for (int c = 0; c < c_NCH; c++)
      if (ch_rd[c]) head[c] <= head[c] + 1;

  always_comb begin
    for (int c = 0; c < c_NCH; c++) begin
      ch_count[c*c_CW +: c_CW] = c_CW'(tot[c] - head[c]);
      ch_data[c*32 +: 32]      = {8'(c), 24'(head[c])};
      ch_addr[c*24 +: 24]      = {4'(c), 20'(head[c])};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] pkt [0:299];
  int pkt_len;

  task automatic capture(input int budget);
    int waited = 0;
    pkt_len = 0;
    while (w_enable !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    while (w_enable === 1'b1 && pkt_len < 300) begin
      pkt[pkt_len] = w_data;
      pkt_len++;
      @(negedge clk);
    end
  endtask

  task automatic check_pkt(input string tag, input int ch, input int n, input bit last, input int h0);
    chk({tag, "_beats"}, pkt_len, 5 + n);
    chk({tag, "_dst_ip"}, pkt[0], cfg_dst_ip);
    chk({tag, "_src_ip"}, pkt[1], cfg_src_ip);
    chk({tag, "_ports"}, pkt[2], {16'(5000 + ch), 16'd1234});
    chk({tag, "_bytes"}, pkt[3], 32'(4 * (n + 1)));
    chk({tag, "_info"}, pkt[4], {last, 7'(ch), 4'(ch), 20'(h0)});
    for (int k = 0; k < n; k++)
      chk({tag, "_data"}, pkt[5 + k], {8'(ch), 24'(h0 + k)});
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    cfg_dst_ip   = 32'hC0A8_0002;
    cfg_src_ip   = 32'hC0A8_0001;
    cfg_dst_port = 16'd1234;
    cfg_src_port = 16'd5000;
    cfg_words    = 9'd256;
    cfg_interval = 24'd0;
    ch_final     = '0;
    w_ack        = 1'b1;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_w_req", w_req, 0);
    chk("rst_w_enable", w_enable, 0);
    chk("rst_ch_rd", ch_rd, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_frame_ch", frame_ch, 0);

    // Full 256-word packet out of 300 words on channel 0.
    tot[0] = 300;
    rst = 1'b0;
    capture(20);
    check_pkt("full", 0, 256, 1'b0, 0);
    chk("full_bytes_0x404", pkt[3], 32'h0000_0404);
    chk("full_left", ch_count[c_CW-1:0], 44);
    capture(30);
    chk("full_no_more", pkt_len, 0);

    // Short final packet, then exactly one frame_done.
    ch_final[0] = 1'b1;
    capture(20);
    check_pkt("short", 0, 44, 1'b1, 256);
    chk("short_bytes_0xb4", pkt[3], 32'h0000_00B4);
    chk("short_info", pkt[4], 32'h8000_0100);
    n = 0;
    while (frame_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fd_seen", frame_done, 1);
    chk("fd_ch", frame_ch, 0);
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      @(negedge clk);
      if (frame_done) cnt_a++;
      if (w_enable) cnt_b++;
    end
    chk("fd_single", cnt_a, 0);
    chk("fd_no_pkt", cnt_b, 0);
    ch_final[0] = 1'b0;

    // Round robin over four full channels, L = 8.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cfg_words = 9'd8;
    tot[0] = 316;
    tot[1] = 16;
    tot[2] = 16;
    tot[3] = 16;
    rst = 1'b0;
    capture(20);
    check_pkt("rr_a0", 0, 8, 1'b0, 300);
    capture(10);
    check_pkt("rr_a1", 1, 8, 1'b0, 0);
    capture(10);
    check_pkt("rr_a2", 2, 8, 1'b0, 0);
    capture(10);
    check_pkt("rr_a3", 3, 8, 1'b0, 0);
    capture(10);
    check_pkt("rr_b0", 0, 8, 1'b0, 308);

    // Grant withheld for 50 cycles.
    w_ack = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    repeat (50) begin
      @(negedge clk);
      if (w_req) cnt_a++;
      if (w_enable) cnt_b++;
      if (ch_rd != 0) cnt_c++;
    end
    chk("stall_req", cnt_a, 50);
    chk("stall_wen", cnt_b, 0);
    chk("stall_rd", cnt_c, 0);
    w_ack = 1'b1;
    @(negedge clk);
    chk("ack_hdr_state", w_enable, 0);
    chk("ack_req_drop", w_req, 0);
    @(negedge clk);
    chk("ack_first_beat", w_enable, 1);
    capture(1);
    check_pkt("stall_pkt", 1, 8, 1'b0, 8);

    // One-word packets with a 100-cycle interval.
    cfg_words    = 9'd0;
    cfg_interval = 24'd100;
    capture(10);
    check_pkt("one_a", 2, 1, 1'b0, 8);
    chk("one_bytes_8", pkt[3], 32'h0000_0008);
    n = 0;
    while (w_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("gap_cycles", n, 101);
    capture(10);
    check_pkt("one_b", 3, 1, 1'b0, 8);

    // Reset during the third data beat.
    cfg_words    = 9'd8;
    cfg_interval = 24'd0;
    tot[0]       = 332;
    n = 0;
    while (w_enable !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rs_first_beat", w_data, 32'hC0A8_0002);
    repeat (6) @(negedge clk);
    chk("rs_rd_beat3", ch_rd, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_w_req", w_req, 0);
    chk("rs_w_enable", w_enable, 0);
    chk("rs_ch_rd", ch_rd, 0);
    chk("rs_frame_done", frame_done, 0);
    chk("rs_w_data", w_data, 0);
    chk("rs_frame_ch", frame_ch, 0);
    rst = 1'b0;
    capture(20);
    check_pkt("rs_after", 0, 8, 1'b0, 319);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
